// File: rtl/k_current_calc.sv
// Hodgkin-Huxley potassium current I_K = gK * n^4 * (V - EK), sequential datapath with
// valid/ready handshakes. Define IK_CONDUCTANCE_OUT_EN to expose the conductance as g_k_out.
module k_current_calc #(
    parameter int GK_X1000 = 36000,
    parameter int EK       = -77,
    parameter int SCALE    = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] n_in,
    input  logic [15:0] V,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] i_k,
    output logic        sat
`ifdef IK_CONDUCTANCE_OUT_EN
    ,
    output logic [31:0] g_k_out
`endif
);

    typedef enum logic [2:0] {StIdle, StSq1, StSq2, StGsc, StDrv, StDone} state_e;

    state_e             state_q, state_d;
    logic signed [31:0] n_c_q, n_c_d;
    logic signed [31:0] n2_q, n2_d;
    logic signed [31:0] n4_q, n4_d;
    logic signed [31:0] g_q, g_d;
    logic signed [16:0] dv_q, dv_d;
    logic               clamp_q, clamp_d;
    logic               out_valid_q, out_valid_d;
    logic               sat_q, sat_d;
    logic        [15:0] i_k_q, i_k_d;

    logic signed [31:0] n_ext;
    logic signed [16:0] v_ext;
    logic signed [31:0] dv_ext;
    logic signed [31:0] r;

    assign n_ext  = {{16{n_in[15]}}, n_in};
    assign v_ext  = {V[15], V};
    assign dv_ext = {{15{dv_q[16]}}, dv_q};
    // Magnitudes stay below 2^31: g <= 36000 and |dv| <= 32845.
    assign r      = (g_q * dv_ext) / SCALE;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign i_k       = i_k_q;
    assign sat       = sat_q;

    always_comb begin
        state_d     = state_q;
        n_c_d       = n_c_q;
        n2_d        = n2_q;
        n4_d        = n4_q;
        g_d         = g_q;
        dv_d        = dv_q;
        clamp_d     = clamp_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        i_k_d       = i_k_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (n_ext < 0) begin
                        n_c_d = '0;
                    end else if (n_ext > SCALE) begin
                        n_c_d = SCALE;
                    end else begin
                        n_c_d = n_ext;
                    end
                    clamp_d = (n_ext < 0) || (n_ext > SCALE);
                    dv_d    = v_ext - 17'(EK);
                    state_d = StSq1;
                end
            end
            StSq1: begin
                n2_d    = (n_c_q * n_c_q) / SCALE;
                state_d = StSq2;
            end
            StSq2: begin
                n4_d    = (n2_q * n2_q) / SCALE;
                state_d = StGsc;
            end
            StGsc: begin
                g_d     = (GK_X1000 * n4_q) / SCALE;
                state_d = StDrv;
            end
            StDrv: begin
                if (r > 32767) begin
                    i_k_d = 16'h7fff;
                    sat_d = 1'b1;
                end else if (r < -32768) begin
                    i_k_d = 16'h8000;
                    sat_d = 1'b1;
                end else begin
                    i_k_d = r[15:0];
                    sat_d = clamp_q;
                end
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            n_c_q       <= '0;
            n2_q        <= '0;
            n4_q        <= '0;
            g_q         <= '0;
            dv_q        <= '0;
            clamp_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            i_k_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_c_q       <= n_c_d;
            n2_q        <= n2_d;
            n4_q        <= n4_d;
            g_q         <= g_d;
            dv_q        <= dv_d;
            clamp_q     <= clamp_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            i_k_q       <= i_k_d;
        end
    end

`ifdef IK_CONDUCTANCE_OUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_k_out <= '0;
        end else if (state_q == StGsc) begin
            g_k_out <= g_d;
        end
    end
`else
    // Conductance stays internal in this build.
`endif

endmodule
